sa_feed_ctrl: RTL
=================

SA_FEED_CTRL -- requirements
Module: sa_feed_ctrl

Interface
REQ-001 SHALL have parameter M, default 4, meaning rows of A and C.
REQ-002 SHALL have parameter K, default 4, meaning the inner dimension (columns of A, rows of B).
REQ-003 SHALL have parameter N, default 4, meaning columns of B and C.
REQ-004 SHALL have parameter PIPE_LAT, default 1, meaning the per-PE register latency of the systolic array.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1 bit: request one M×K×N product.
REQ-008 SHALL have port abort, input, 1 bit: synchronously cancel the operation in progress.
REQ-009 SHALL have port feed_stall, input, 1 bit: the operand source is not ready this cycle.
REQ-010 SHALL have port result_ack, input, 1 bit: the consumer has taken C.
REQ-011 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-012 SHALL have port acc_clr, output, 1 bit: clears all PE accumulators.
REQ-013 SHALL have port feed_valid, output, 1 bit: the A column and B row at feed_k enter the array skew front-end this cycle.
REQ-014 SHALL have port feed_k, output, clog2(K) bits (minimum 1): the inner-dimension index being fed.
REQ-015 SHALL have port c_capture, output, 1 bit: latches the array outputs into the result register.
REQ-016 SHALL have port result_valid, output, 1 bit: C is stable and owned by the consumer.
REQ-017 SHALL have port lat_cnt, output, 16 bits: cycle count of the last completed operation.

Function
REQ-018 SHALL implement the states IDLE, CLEAR, FEED, DRAIN, CAPTURE and DONE.
REQ-019 In IDLE, start=1 SHALL move to CLEAR; in all other states start SHALL be ignored.
REQ-020 In CLEAR, acc_clr SHALL be 1 for exactly one cycle, then the FSM SHALL move to FEED with feed_k=0.
REQ-021 FEED transfer rules:
- When feed_stall=0, feed_valid SHALL be 1 and feed_k SHALL increment after each such cycle.
- When feed_stall=1, feed_valid SHALL be 0 and feed_k SHALL hold.
- After the unstalled cycle with feed_k=K-1, the FSM SHALL move to DRAIN.
REQ-022 DRAIN SHALL last exactly DRAIN_CYC = M+N-2+PIPE_LAT cycles with feed_valid=0; feed_stall SHALL be ignored.
REQ-023 In CAPTURE, c_capture SHALL be 1 for one cycle, then the FSM SHALL move to DONE.
REQ-024 In DONE, result_valid SHALL be 1 and held until result_ack=1 is sampled, then the FSM SHALL return to IDLE; start in the same cycle SHALL be ignored.
REQ-025 The in-flight counter SHALL count every cycle spent in CLEAR through CAPTURE inclusive, saturating at 0xFFFF; lat_cnt SHALL load it on entry to DONE and hold otherwise.
REQ-026 For the default parameters with no stalls, lat_cnt SHALL be 13, and result_valid SHALL rise 13 cycles after the edge that samples start.
REQ-027 abort=1 SHALL force IDLE at the next edge from any state; it SHALL have priority over start and result_ack, SHALL NOT assert c_capture, and SHALL NOT update lat_cnt.
REQ-028 acc_clr, feed_valid, c_capture and result_valid SHALL be registered outputs with no combinational path from any input.
REQ-029 feed_k SHALL read 0 outside FEED.

Reset
REQ-030 While reset_n=0, the state SHALL be IDLE and busy, acc_clr, feed_valid, feed_k, c_capture, result_valid and lat_cnt SHALL all be 0, immediately and asynchronously.
REQ-031 Reset asserted mid-operation SHALL discard the operation; after release, the block SHALL await a new start.

Structure
REQ-032 Package sa_pkg SHALL hold the state enum, the DRAIN_CYC function and the lat_cnt width constant.
REQ-033 A single sub-module, sa_cycle_counter (loadable down-counter with a zero flag), SHALL time the DRAIN state.

Verification
REQ-034 Defaults, start pulse, no stalls, then ack: acc_clr for 1 cycle, feed_k 0,1,2,3 on consecutive cycles, 7 DRAIN cycles, c_capture for 1 cycle, lat_cnt=13.
REQ-035 feed_stall=1 for 2 cycles while feed_k=1: feed_k holds at 1 with feed_valid=0, then continues; lat_cnt=15.
REQ-036 abort on the 3rd DRAIN cycle: IDLE next cycle, c_capture never asserts, lat_cnt keeps its previous value.
REQ-037 result_ack delayed 5 cycles with start pulsed in DONE: result_valid holds for 5 cycles, start is ignored, busy=0 after the ack.
REQ-038 reset_n dropped mid-FEED: all outputs are 0 before the next clock edge; a new start after release runs the nominal sequence.
REQ-039 M=2, K=3, N=5, PIPE_LAT=2, no stalls: DRAIN=7 cycles, feed_k 0..2, lat_cnt=12.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared types and helpers for the systolic-array feed controller.
package sa_pkg;

  localparam int LAT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_DRAIN,
    ST_CAPTURE,
    ST_DONE
  } sa_state_e;

  // Cycles for the last operand to skew through the array and leave the far PE.
  function automatic int drain_cyc(input int m, input int n, input int pipe_lat);
    return m + n - 2 + pipe_lat;
  endfunction

  function automatic logic [LAT_W-1:0] sat_inc(input logic [LAT_W-1:0] v);
    return (v == '1) ? v : v + LAT_W'(1);
  endfunction

endpackage

// File: rtl/sa_cycle_counter.sv
// Loadable down-counter with zero flag; load wins over enable, stops at zero.
// Zero flag is decoded straight from the count register.
module sa_cycle_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/sa_feed_ctrl.sv
// Sequences one MxKxN systolic product: clear, feed K operand slices, drain, capture, hand off.
// All outputs come from registers; feed_stall sampled at an edge decides whether the next cycle feeds.
module sa_feed_ctrl
  import sa_pkg::*;
#(
  parameter int M        = 4,
  parameter int K        = 4,
  parameter int N        = 4,
  parameter int PIPE_LAT = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          feed_stall,
  input  logic                          result_ack,
  output logic                          busy,
  output logic                          acc_clr,
  output logic                          feed_valid,
  output logic [$clog2(K>1?K:2)-1:0]    feed_k,
  output logic                          c_capture,
  output logic                          result_valid,
  output logic [LAT_W-1:0]              lat_cnt
);

  localparam int                KW         = $clog2(K > 1 ? K : 2);
  localparam int                DRAIN_CYC  = drain_cyc(M, N, PIPE_LAT);
  localparam logic [KW-1:0]     K_LAST     = KW'(K - 1);
  localparam logic [LAT_W-1:0]  DRAIN_LOAD = LAT_W'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);

  sa_state_e        state_q, state_d;
  logic [KW-1:0]    feed_k_q, feed_k_d;
  logic             feed_vld_q, feed_vld_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic             drain_load, drain_en, drain_zero;

  sa_cycle_counter #(.W(LAT_W)) u_drain_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (drain_load),
    .load_val_i (DRAIN_LOAD),
    .en_i       (drain_en),
    .zero_o     (drain_zero)
  );

  always_comb begin
    state_d    = state_q;
    feed_k_d   = feed_k_q;
    feed_vld_d = 1'b0;
    cnt_d      = cnt_q;
    lat_d      = lat_q;
    drain_load = 1'b0;
    drain_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        cnt_d   = sat_inc(cnt_q);
        state_d = ST_FEED;
      end
      ST_FEED: begin
        cnt_d = sat_inc(cnt_q);
        // feed_vld_q marks a transfer in this cycle, so the index advances only after one.
        if (feed_vld_q) begin
          if (feed_k_q == K_LAST) begin
            state_d    = (DRAIN_CYC > 0) ? ST_DRAIN : ST_CAPTURE;
            drain_load = 1'b1;
          end else begin
            feed_k_d = feed_k_q + KW'(1);
          end
        end
      end
      ST_DRAIN: begin
        cnt_d    = sat_inc(cnt_q);
        drain_en = 1'b1;
        if (drain_zero) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        cnt_d   = sat_inc(cnt_q);
        lat_d   = sat_inc(cnt_q);
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (result_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d = ST_IDLE;
      lat_d   = lat_q;
    end

    if (state_d == ST_FEED) begin
      feed_vld_d = !feed_stall;
    end else begin
      feed_k_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      feed_k_q   <= '0;
      feed_vld_q <= 1'b0;
      cnt_q      <= '0;
      lat_q      <= '0;
    end else begin
      state_q    <= state_d;
      feed_k_q   <= feed_k_d;
      feed_vld_q <= feed_vld_d;
      cnt_q      <= cnt_d;
      lat_q      <= lat_d;
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign acc_clr      = (state_q == ST_CLEAR);
  assign c_capture    = (state_q == ST_CAPTURE);
  assign result_valid = (state_q == ST_DONE);
  assign feed_valid   = feed_vld_q;
  assign feed_k       = feed_k_q;
  assign lat_cnt      = lat_q;

endmodule
